// File: rtl/sram_access_arbiter_if.sv
// Bus bundle between the SRAM access arbiter and its surroundings.
// It carries the 68k CPU request/data path, the DMA master port and the SRAM
// chip interface. The arbiter uses the slave view. The master view is the
// decoder/CPU/DMA/SRAM side.
interface sram_access_arbiter_if;
  // 68k CPU side
  logic        CpuReq_H;
  logic [16:0] CpuAddress;
  logic        CpuRead_H;
  logic        CpuUDS_L;
  logic        CpuLDS_L;
  logic [15:0] CpuWriteData;
  logic [15:0] CpuReadData;
  logic        CpuDtack_L;
  // DMA / video master side
  logic        DmaReq_H;
  logic [16:0] DmaAddress;
  logic        DmaWrite_H;
  logic [15:0] DmaWriteData;
  logic [15:0] DmaReadData;
  logic        DmaAck_H;
  // SRAM chips
  logic [14:0] SramAddress;
  logic [3:0]  SramBlock_H;
  logic        SramOE_L;
  logic        SramWE_L;
  logic        SramUB_L;
  logic        SramLB_L;
  logic [15:0] SramDataOut;
  logic        SramDataOutEn_H;
  logic [15:0] SramDataIn;

  modport slave (
    input  CpuReq_H, CpuAddress, CpuRead_H, CpuUDS_L, CpuLDS_L, CpuWriteData,
    input  DmaReq_H, DmaAddress, DmaWrite_H, DmaWriteData,
    input  SramDataIn,
    output CpuReadData, CpuDtack_L,
    output DmaReadData, DmaAck_H,
    output SramAddress, SramBlock_H, SramOE_L, SramWE_L, SramUB_L, SramLB_L,
    output SramDataOut, SramDataOutEn_H
  );

  modport master (
    output CpuReq_H, CpuAddress, CpuRead_H, CpuUDS_L, CpuLDS_L, CpuWriteData,
    output DmaReq_H, DmaAddress, DmaWrite_H, DmaWriteData,
    output SramDataIn,
    input  CpuReadData, CpuDtack_L,
    input  DmaReadData, DmaAck_H,
    input  SramAddress, SramBlock_H, SramOE_L, SramWE_L, SramUB_L, SramLB_L,
    input  SramDataOut, SramDataOutEn_H
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// SRAM access arbiter. It shares the 4-block SRAM between the 68k CPU and a
// DMA/video master. It sequences IDLE -> SETUP -> ACCESS -> DONE -> RECOVER,
// holds OE_L/WE_L low for ACCESS_CYCLES clocks (legal 1..15), returns DTACK to
// the CPU and a one-cycle acknowledge to DMA.
//
// Every output is a flop. Each _d value is the value the output takes in the
// next state, so strobes line up exactly with the state they belong to.
//
// Optional macro SRAM_RR_ARB_EN: round-robin arbitration on simultaneous
// requests. Without it the CPU always wins a tie.
module sram_access_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input logic                   Clock,
  input logic                   Reset_H,
  sram_access_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_RECOVER
  } state_t;

  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_DMA = 1'b1;
  localparam logic [3:0] ACC_LAST  = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        write_q, write_d;
  logic [14:0] sram_addr_q, sram_addr_d;
  logic [3:0]  block_q, block_d;
  logic        oe_l_q, oe_l_d;
  logic        we_l_q, we_l_d;
  logic        ub_l_q, ub_l_d;
  logic        lb_l_q, lb_l_d;
  logic [15:0] dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] dma_rdata_q, dma_rdata_d;
  logic        dtack_l_q, dtack_l_d;
  logic        ack_q, ack_d;
`ifdef SRAM_RR_ARB_EN
  logic        last_owner_q, last_owner_d;
`endif

  logic        grant_dma;
  logic [16:0] sel_addr;
  logic        sel_write;
  logic [15:0] sel_wdata;
  logic        sel_ub_l;
  logic        sel_lb_l;
  logic        unused_addr_lsb;

  // Arbitration: pick which requester gets the SRAM when IDLE sees a request.
`ifdef SRAM_RR_ARB_EN
  // On a tie, DMA wins only if the CPU owned the previous access.
  assign grant_dma = bus.DmaReq_H && (!bus.CpuReq_H || (last_owner_q == OWNER_CPU));
`else
  assign grant_dma = bus.DmaReq_H && !bus.CpuReq_H;
`endif

  // Winner's transaction fields, latched on the IDLE -> SETUP transition.
  // The DMA port always moves full words.
  assign sel_addr        = grant_dma ? bus.DmaAddress   : bus.CpuAddress;
  assign sel_write       = grant_dma ? bus.DmaWrite_H   : !bus.CpuRead_H;
  assign sel_wdata       = grant_dma ? bus.DmaWriteData : bus.CpuWriteData;
  assign sel_ub_l        = grant_dma ? 1'b0 : bus.CpuUDS_L;
  assign sel_lb_l        = grant_dma ? 1'b0 : bus.CpuLDS_L;
  // Byte address bit 0 has no meaning on a 16-bit word bus.
  assign unused_addr_lsb = sel_addr[0];

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    write_d     = write_q;
    sram_addr_d = sram_addr_q;
    block_d     = block_q;
    oe_l_d      = oe_l_q;
    we_l_d      = we_l_q;
    ub_l_d      = ub_l_q;
    lb_l_d      = lb_l_q;
    dout_d      = dout_q;
    dout_en_d   = dout_en_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    dtack_l_d   = dtack_l_q;
    ack_d       = 1'b0;
`ifdef SRAM_RR_ARB_EN
    last_owner_d = last_owner_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.CpuReq_H || bus.DmaReq_H) begin
          state_d     = S_SETUP;
          owner_d     = grant_dma ? OWNER_DMA : OWNER_CPU;
          write_d     = sel_write;
          // Bit 15 selects the block, so it is cleared from the word offset.
          sram_addr_d = {1'b0, sel_addr[14:1]};
          block_d     = 4'b0001 << sel_addr[16:15];
          ub_l_d      = sel_ub_l;
          lb_l_d      = sel_lb_l;
          dout_d      = sel_wdata;
          dout_en_d   = sel_write;
`ifdef SRAM_RR_ARB_EN
          last_owner_d = grant_dma ? OWNER_DMA : OWNER_CPU;
`endif
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = ACC_LAST;
        oe_l_d  = write_q;
        we_l_d  = !write_q;
      end

      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_DONE;
          oe_l_d    = 1'b1;
          we_l_d    = 1'b1;
          ub_l_d    = 1'b1;
          lb_l_d    = 1'b1;
          block_d   = 4'b0000;
          dout_en_d = 1'b0;
          if (!write_q) begin
            if (owner_q == OWNER_DMA) dma_rdata_d = bus.SramDataIn;
            else                      cpu_rdata_d = bus.SramDataIn;
          end
          if (owner_q == OWNER_DMA) ack_d     = 1'b1;
          // A CPU that already gave up the cycle gets no DTACK at all.
          else                      dtack_l_d = !bus.CpuReq_H;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        // Hold DTACK until the 68k releases its request.
        if (owner_q == OWNER_DMA || dtack_l_q || !bus.CpuReq_H) begin
          state_d   = S_RECOVER;
          dtack_l_d = 1'b1;
        end
      end

      S_RECOVER: begin
        state_d   = S_IDLE;
        dtack_l_d = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. A reset aborts any access in flight.
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWNER_CPU;
      write_q     <= 1'b0;
      sram_addr_q <= 15'd0;
      block_q     <= 4'b0000;
      oe_l_q      <= 1'b1;
      we_l_q      <= 1'b1;
      ub_l_q      <= 1'b1;
      lb_l_q      <= 1'b1;
      dout_q      <= 16'd0;
      dout_en_q   <= 1'b0;
      cpu_rdata_q <= 16'd0;
      dma_rdata_q <= 16'd0;
      dtack_l_q   <= 1'b1;
      ack_q       <= 1'b0;
`ifdef SRAM_RR_ARB_EN
      last_owner_q <= OWNER_DMA;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      sram_addr_q <= sram_addr_d;
      block_q     <= block_d;
      oe_l_q      <= oe_l_d;
      we_l_q      <= we_l_d;
      ub_l_q      <= ub_l_d;
      lb_l_q      <= lb_l_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      dtack_l_q   <= dtack_l_d;
      ack_q       <= ack_d;
`ifdef SRAM_RR_ARB_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  assign bus.CpuReadData     = cpu_rdata_q;
  assign bus.CpuDtack_L      = dtack_l_q;
  assign bus.DmaReadData     = dma_rdata_q;
  assign bus.DmaAck_H        = ack_q;
  assign bus.SramAddress     = sram_addr_q;
  assign bus.SramBlock_H     = block_q;
  assign bus.SramOE_L        = oe_l_q;
  assign bus.SramWE_L        = we_l_q;
  assign bus.SramUB_L        = ub_l_q;
  assign bus.SramLB_L        = lb_l_q;
  assign bus.SramDataOut     = dout_q;
  assign bus.SramDataOutEn_H = dout_en_q;

endmodule
